// File: rtl/sobel_window_engine.sv
// Streaming 3x3 Sobel edge filter between two FWFT FIFOs: two internal line buffers,
// zeroed borders, magnitude / threshold / passthrough output, full backpressure.
module sobel_window_engine #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int PIXEL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_empty,
    input  logic [PIXEL_W-1:0] in_dout,
    output logic               in_rd_en,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [PIXEL_W-1:0] out_din,
    input  logic [1:0]         mode,
    input  logic [PIXEL_W-1:0] threshold,
    output logic               frame_done
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int SW   = PIXEL_W + 3;
    localparam int SUMW = PIXEL_W + 4;

    localparam logic [CW-1:0]      COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [PIXEL_W-1:0] PIX_MAX  = '1;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    logic [CW-1:0]      in_col;
    logic [RW-1:0]      in_row;
    logic [CW-1:0]      o_col;
    logic [RW-1:0]      o_row;
    logic [1:0]         mode_q;
    logic [PIXEL_W-1:0] thr_q;
    logic               out_v;
    logic               out_last;
    logic [PIXEL_W-1:0] out_q;

    logic [PIXEL_W-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_W-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_W-1:0] win [3][3];
    logic [PIXEL_W-1:0] nw  [3][3];

    logic               out_ready;
    logic               adv;
    logic               load;
    logic [CW-1:0]      addr;
    logic [PIXEL_W-1:0] new_pix;
    logic               border;
    logic               o_at_end;

    logic [SW-1:0]      gx_p, gx_n, gy_p, gy_n, gx, gy, ax, ay;
    logic [SUMW-1:0]    s;
    logic [PIXEL_W-1:0] result;

    assign out_ready = ~out_v | ~out_full;
    assign o_at_end  = (o_col == COL_LAST) && (o_row == ROW_LAST);
    assign border    = (o_row == '0) || (o_row == ROW_LAST) || (o_col == '0) || (o_col == COL_LAST);

    always_comb begin
        adv = 1'b0;
        case (state)
            FILL:    adv = ~in_empty;
            RUN:     adv = ~in_empty & out_ready;
            FLUSH:   adv = out_ready;
            default: adv = 1'b0;
        endcase
    end

    assign in_rd_en = ~rst & adv & (state != FLUSH);
    assign load     = adv & (state != FILL);

    // During FLUSH there is no input; the column address keeps tracking one column
    // ahead of the output so the window still slides the stored last lines through.
    assign addr    = (state == FLUSH) ? ((o_col == COL_LAST) ? '0 : o_col + CW'(1)) : in_col;
    assign new_pix = (state == FLUSH) ? '0 : in_dout;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = lb1[addr];
        nw[1][2] = lb0[addr];
        nw[2][2] = new_pix;
    end

    // Sums fit in PIXEL_W+2 unsigned bits, so the PIXEL_W+3 bit difference wraps to a
    // correct two's-complement gradient.
    always_comb begin
        gx_p = SW'(nw[0][2]) + (SW'(nw[1][2]) << 1) + SW'(nw[2][2]);
        gx_n = SW'(nw[0][0]) + (SW'(nw[1][0]) << 1) + SW'(nw[2][0]);
        gy_p = SW'(nw[2][0]) + (SW'(nw[2][1]) << 1) + SW'(nw[2][2]);
        gy_n = SW'(nw[0][0]) + (SW'(nw[0][1]) << 1) + SW'(nw[0][2]);
        gx   = gx_p - gx_n;
        gy   = gy_p - gy_n;
        ax   = gx[SW-1] ? -gx : gx;
        ay   = gy[SW-1] ? -gy : gy;
        s    = SUMW'(ax) + SUMW'(ay);
    end

    always_comb begin
        result = '0;
        case (mode_q)
            2'd2: result = nw[1][1];
            2'd1: result = (!border && (s > SUMW'(thr_q))) ? PIX_MAX : '0;
            default: begin
                if (!border)
                    result = (s > SUMW'(PIX_MAX)) ? PIX_MAX : s[PIXEL_W-1:0];
            end
        endcase
    end

    // NOTE: line buffers and the window are pure datapath storage and are deliberately
    // left out of reset; every value they feed to a non-border output is rewritten first.
    always_ff @(posedge clk) begin
        if (adv) begin
            lb0[addr] <= new_pix;
            lb1[addr] <= lb0[addr];
            win       <= nw;
        end
    end

    // NOTE: all state below uses non-blocking assignments so the later load can
    // override the write-clear of out_v within the same edge without ordering hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            in_col   <= '0;
            in_row   <= '0;
            o_col    <= '0;
            o_row    <= '0;
            mode_q   <= '0;
            thr_q    <= '0;
            out_v    <= 1'b0;
            out_last <= 1'b0;
            out_q    <= '0;
        end else begin
            if (out_wr_en)
                out_v <= 1'b0;

            if (load) begin
                out_v    <= 1'b1;
                out_q    <= result;
                out_last <= o_at_end;
                o_col    <= (o_col == COL_LAST) ? '0 : o_col + CW'(1);
                if (o_col == COL_LAST)
                    o_row <= (o_row == ROW_LAST) ? '0 : o_row + RW'(1);
            end

            if (in_rd_en) begin
                in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
                if (in_col == COL_LAST)
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
            end

            case (state)
                FILL: begin
                    if (adv && in_col == '0 && in_row == '0) begin
                        mode_q <= mode;
                        thr_q  <= threshold;
                    end
                    if (adv && in_col == '0 && in_row == RW'(1))
                        state <= RUN;
                end
                RUN: begin
                    if (adv && in_col == COL_LAST && in_row == ROW_LAST)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (adv && o_at_end)
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign out_wr_en  = out_v & ~out_full;
    assign out_din    = out_q;
    assign frame_done = out_wr_en & out_last;

endmodule
